// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
// Used by serial_subtractor (optional SERIAL_SUBTRACTOR_SIGNED_FLAGS_EN build).
package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/full_subtractor_bit.sv
// One-bit full subtractor cell: diff = a - b - bin with borrow out.
// Borrow counterpart of the ripple-carry adder cell.
module full_subtractor_bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, D = A - B, LSB first, valid/ready on both sides.
// Define SERIAL_SUBTRACTOR_SIGNED_FLAGS_EN to add registered overflow/negative outputs.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             borrow
`ifdef SERIAL_SUBTRACTOR_SIGNED_FLAGS_EN
    ,
    output logic             overflow,
    output logic             negative
`endif
);

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [CNT_W-1:0] cnt_q;
    logic             bor_q;
    logic [WIDTH-1:0] d_q;
    logic             borrow_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic             diff, bout;
    logic [WIDTH-1:0] a_d, b_d;
    logic [CNT_W-1:0] cnt_d;
    logic             last_shift;

    full_subtractor_bit u_cell (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (bor_q),
        .diff (diff),
        .bout (bout)
    );

    // The minuend register doubles as the result register: each freed MSB takes the new diff bit.
    // NOTE: every signal written here gets a value on every path, so no latch is inferred.
    always_comb begin
        a_d        = {diff, a_q[WIDTH-1:1]};
        b_d        = {1'b0, b_q[WIDTH-1:1]};
        cnt_d      = cnt_q + CNT_W'(1);
        last_shift = (cnt_q == CNT_W'(WIDTH - 1));
    end

`ifdef SERIAL_SUBTRACTOR_SIGNED_FLAGS_EN
    logic overflow_q, negative_q;

    // On the final shift a_q[0]/b_q[0] hold the original operand MSBs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
            negative_q <= 1'b0;
        end else if (ena && state_q == SHIFT && last_shift) begin
            overflow_q <= (a_q[0] ^ b_q[0]) & (a_q[0] ^ diff);
            negative_q <= diff;
        end
    end

    assign overflow = overflow_q;
    assign negative = negative_q;
`endif

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: datapath registers are reset too, so d reads 0 and no X leaks out before the first result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            cnt_q       <= '0;
            bor_q       <= 1'b0;
            d_q         <= '0;
            borrow_q    <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else if (ena) begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= b;
                        bor_q      <= 1'b0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_q   <= a_d;
                    b_q   <= b_d;
                    bor_q <= bout;
                    cnt_q <= cnt_d;
                    if (last_shift) begin
                        d_q         <= a_d;
                        borrow_q    <= bout;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    // in_ready only rises after this edge, so no accept shares the output handshake cycle.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign d         = d_q;
    assign borrow    = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: stimulus pushes expected results, a monitor pops on handshake.
// Build with SERIAL_SUBTRACTOR_SIGNED_FLAGS_EN to also check overflow/negative.
module tb_serial_subtractor;
    import serial_sub_pkg::*;

    localparam int WIDTH = DEFAULT_WIDTH;

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic             borrow;
        logic             ovf;
        logic             neg;
    } exp_t;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             ena       = 1'b1;
    logic             in_valid  = 1'b0;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] a         = '0;
    logic [WIDTH-1:0] b         = '0;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] d;
    logic             borrow;
`ifdef SERIAL_SUBTRACTOR_SIGNED_FLAGS_EN
    logic             overflow;
    logic             negative;
`endif

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .borrow    (borrow)
`ifdef SERIAL_SUBTRACTOR_SIGNED_FLAGS_EN
        ,
        .overflow  (overflow),
        .negative  (negative)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [WIDTH-1:0] dv, input logic bv, input logic ov, input logic nv);
        mk = '{d: dv, borrow: bv, ovf: ov, neg: nv};
    endfunction

    // Monitor: compares against the scoreboard whenever a result handshake is presented.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid === 1'b1 && out_ready) begin
                check("sb_nonempty", 32'(sb_q.size() > 0), 1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check("d", d, e.d);
                    check("borrow", borrow, e.borrow);
`ifdef SERIAL_SUBTRACTOR_SIGNED_FLAGS_EN
                    check("overflow", overflow, e.ovf);
                    check("negative", negative, e.neg);
`endif
                end
            end
        end
    end

    task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input exp_t e,
                          input int hold, input bit ena_gap, input string tag);
        int n;
        @(negedge clk);
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_in_ready_idle"}, in_ready, 1);
        a         = av;
        b         = bv;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = ~av;
        b        = ~bv;
        check({tag, "_in_ready_busy"}, in_ready, 0);
        n = 0;
        while (out_valid !== 1'b1 && n < 30) begin
            @(posedge clk);
            #1;
            n++;
            if (ena_gap) ena = !(n >= 1 && n <= 3);
        end
        ena = 1'b1;
        check({tag, "_latency"}, n, WIDTH + (ena_gap ? 3 : 0));
        repeat (hold) begin
            @(posedge clk);
            #1;
            check({tag, "_hold_valid"}, out_valid, 1);
            check({tag, "_hold_in_ready"}, in_ready, 0);
            check({tag, "_hold_d"}, d, e.d);
            check({tag, "_hold_borrow"}, borrow, e.borrow);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_in_ready_after"}, in_ready, 1);
        check({tag, "_valid_after"}, out_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_d", d, 0);
        check("rst_borrow", borrow, 0);
`ifdef SERIAL_SUBTRACTOR_SIGNED_FLAGS_EN
        check("rst_overflow", overflow, 0);
        check("rst_negative", negative, 0);
`endif
        rst_n = 1'b1;

        run_op(4'd9,  4'd3,  mk(4'h6, 1'b0, 1'b1, 1'b0), 0, 1'b0, "sub_9_3");
        // 3 - (-7) = +10 exceeds the 4-bit signed range.
        run_op(4'd3,  4'd9,  mk(4'hA, 1'b1, 1'b1, 1'b1), 0, 1'b0, "sub_3_9");
        run_op(4'd0,  4'd1,  mk(4'hF, 1'b1, 1'b0, 1'b1), 0, 1'b0, "sub_0_1");
        run_op(4'd15, 4'd15, mk(4'h0, 1'b0, 1'b0, 1'b0), 0, 1'b0, "sub_15_15");
        run_op(4'd7,  4'hF,  mk(4'h8, 1'b1, 1'b1, 1'b1), 0, 1'b0, "sub_7_f");
        run_op(4'd6,  4'd10, mk(4'hC, 1'b1, 1'b1, 1'b1), 5, 1'b0, "backpressure");
        run_op(4'd12, 4'd5,  mk(4'h7, 1'b0, 1'b1, 1'b0), 0, 1'b1, "ena_gap");

        // Asynchronous reset two shifts into an operation; the partial result is discarded.
        @(negedge clk);
        a        = 4'd9;
        b        = 4'd3;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_d", d, 0);
        check("midrst_borrow", borrow, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(4'd5, 4'd2, mk(4'h3, 1'b0, 1'b0, 1'b0), 0, 1'b0, "after_rst");

        repeat (3) @(negedge clk);
        check("sb_drain", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
